// File: rtl/parity_checker.sv
// parity_checker: even-parity check stage with error statistics and an error-tag log.
// Define PARITY_CHK_LOG_EN to build the LOG_DEPTH-entry error-tag FIFO; otherwise the log ports read as zero.
module parity_checker #(
    parameter int WIDTH     = 8,
    parameter int TAG_W     = 6,
    parameter int CNT_W     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_parity,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       err_state,
    output logic [TAG_W-1:0] first_err_tag,
    input  logic             clr_err,
    output logic             log_valid,
    output logic [TAG_W-1:0] log_tag,
    input  logic             log_pop,
    output logic             log_ovf
);
    typedef enum logic [1:0] {CLEAN = 2'd0, ERROR = 2'd1, SATUR = 2'd2} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state;
    logic             accept, err, hit, restart;
    logic [CNT_W-1:0] base, cnt_next;
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign err       = ^{in_data, in_parity};
    assign hit       = accept && err;
    assign err_state = state;
    // A clear arriving with an error restarts the statistics from this word.
    always_comb begin
        restart  = clr_err || state == CLEAN;
        base     = restart ? '0 : err_count;
        cnt_next = base == CNT_MAX ? base : base + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_tag   <= in_tag;
            out_err   <= err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count     <= '0;
            state         <= CLEAN;
            first_err_tag <= '0;
        end else if (hit) begin
            err_count     <= cnt_next;
            state         <= cnt_next == CNT_MAX ? SATUR : ERROR;
            first_err_tag <= restart ? in_tag : first_err_tag;
        end else if (clr_err) begin
            err_count     <= '0;
            state         <= CLEAN;
            first_err_tag <= '0;
        end
    end
`ifdef PARITY_CHK_LOG_EN
    localparam int AW = LOG_DEPTH > 1 ? $clog2(LOG_DEPTH) : 1;
    localparam int FW = AW + 1;
    logic [TAG_W-1:0] mem [LOG_DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [FW-1:0]    fill;
    logic             full, push, pop;
    assign full      = fill == FW'(LOG_DEPTH);
    assign log_valid = fill != '0;
    assign pop       = log_pop && log_valid;
    assign push      = hit && (!full || pop);
    assign log_tag   = log_valid ? mem[rp] : '0;
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= in_tag;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp      <= '0;
            rp      <= '0;
            fill    <= '0;
            log_ovf <= 1'b0;
        end else begin
            wp      <= push ? wp + 1'b1 : wp;
            rp      <= pop ? rp + 1'b1 : rp;
            fill    <= fill + FW'(push) - FW'(pop);
            log_ovf <= (log_ovf && !clr_err) || (hit && !push);
        end
    end
`else
    logic unused_log_pop;
    assign unused_log_pop = log_pop;
    assign log_valid      = 1'b0;
    assign log_tag        = '0;
    assign log_ovf        = 1'b0;
`endif
endmodule

// File: doc/parity_checker.md
PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, data bits checked; TAG_W, 6, tag width; CNT_W, 8, error counter width; LOG_DEPTH, 4, error-log entries (power of 2).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  input word valid.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 in_data  input  WIDTH  data word read from storage.
REQ-007 in_parity  input  1  stored even-parity bit for in_data.
REQ-008 in_tag  input  TAG_W  word identifier (address/index).
REQ-009 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-010 out_data  output  WIDTH  checked data; out_tag  output  TAG_W; out_err  output  1  parity mismatch on this word.
REQ-011 err_count  output  CNT_W  saturating mismatch count; err_state  output  2  error FSM state; first_err_tag  output  TAG_W  tag of first error since clear.
REQ-012 clr_err  input  1  clears counter, FSM, first_err_tag.
REQ-013 log_valid  output  1; log_tag  output  TAG_W; log_pop  input  1; log_ovf  output  1  error-log FIFO interface.

Function
REQ-014 Mismatch SHALL be XOR-reduction of in_data XOR in_parity; 1 = error (even parity).
REQ-015 Transfer occurs when valid && ready on either port.
REQ-016 Single output register stage; latency 1 cycle from input accept to out_valid.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational); full throughput under continuous out_ready.
REQ-018 out_data/out_tag/out_err SHALL hold stable while out_valid && !out_ready.
REQ-019 Error FSM states: CLEAN=0, ERROR=1, SATUR=2; CLEAN->ERROR on accepted error; ERROR->SATUR when err_count reaches 2^CNT_W-1; any state->CLEAN on clr_err without simultaneous error.
REQ-020 err_count increments by 1 per accepted erroneous word, saturates at 2^CNT_W-1, never wraps.
REQ-021 first_err_tag captured only on the CLEAN->ERROR transition; held until clr_err.
REQ-022 clr_err coincident with an accepted error: error wins -> err_count=1, err_state=ERROR, first_err_tag=that tag.
REQ-023 Statistics update on input accept (same edge the word enters the output register).

Reset
REQ-024 On reset_n=0 at clk edge: out_valid=0, out_data=0, out_tag=0, out_err=0, err_count=0, err_state=CLEAN, first_err_tag=0, log empty, log_valid=0, log_tag=0, log_ovf=0.
REQ-025 Reset mid-transfer SHALL discard the held word; in_ready=1 on first cycle after reset release.

Configuration
REQ-026 Macro PARITY_CHK_LOG_EN defined: LOG_DEPTH-entry FIFO pushes in_tag of each accepted erroneous word; log_valid=!empty; log_tag=head; pop on log_pop && log_valid; push when full and no pop -> dropped, log_ovf set sticky until clr_err; push+pop when full -> both occur; pop on empty ignored.
REQ-027 Macro undefined: ports remain; log_valid=0, log_tag=0, log_ovf=0, log_pop ignored, no FIFO storage.

Verification
REQ-028 Reset, then in_data=8'hA5, in_parity=0, tag=3, out_ready=1 -> next cycle out_valid=1, out_err=0, err_count=0, err_state=CLEAN.
REQ-029 in_data=8'h01, in_parity=0, tag=5 then in_data=8'h03, in_parity=1, tag=9 -> err_count=2, first_err_tag=5, err_state=ERROR.
REQ-030 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first accept, out_data unchanged, no word lost or duplicated after release.
REQ-031 CNT_W=2, 4 erroneous words -> err_count=3, err_state=SATUR; clr_err with error word tag=7 -> err_count=1, first_err_tag=7, ERROR.
REQ-032 PARITY_CHK_LOG_EN, 5 errors tags 1..5, no pop -> log_ovf=1, pops return 1,2,3,4 then log_valid=0; undefined -> log_valid stays 0.
REQ-033 reset_n=0 while out_valid=1 && out_ready=0 -> next cycle out_valid=0, err_count=0, in_ready=1.
